or_force_unit: RTL
==================

OR_FORCE_UNIT -- requirements
Module: or_force_unit

Interface
REQ-001 SHALL have parameter W, default 2, meaning bit width of each input channel and of the output.
REQ-002 SHALL have parameter N, default 2, meaning number of input channels OR-reduced per bit (N >= 2).
REQ-003 SHALL have parameter HOLD_MAX, default 15, meaning maximum auto-release hold count in cycles; HW = $clog2(HOLD_MAX+1).
REQ-004 SHALL have port clk, input, 1, meaning single clock, rising edge.
REQ-005 SHALL have port rst_n, input, 1, meaning reset, asynchronous, active-low.
REQ-006 SHALL have port in_bus, input, N*W, meaning channel k in bits [k*W +: W].
REQ-007 SHALL have port cmd_valid, input, 1, meaning command offered.
REQ-008 SHALL have port cmd_ready, output, 1, meaning command can be accepted.
REQ-009 SHALL have port cmd_op, input, 2, meaning 00 NOP, 01 FORCE, 10 RELEASE, 11 RELEASE_ALL.
REQ-010 SHALL have port cmd_mask, input, W, meaning bits targeted by FORCE/RELEASE.
REQ-011 SHALL have port cmd_value, input, W, meaning forced values for FORCE.
REQ-012 SHALL have port cmd_hold, input, HW, meaning FORCE hold cycles; 0 = indefinite.
REQ-013 SHALL have port out_q, output, W, meaning registered OR result with overrides.
REQ-014 SHALL have port forced, output, W, meaning current force mask.
REQ-015 SHALL have port rel_pulse, output, 1, meaning one-cycle pulse on timer auto-release.

Function
REQ-016 Per bit b: raw[b] = OR over k of in_bus[k*W+b]; out_q SHALL register (forced & fval) | (~forced & raw) each cycle, latency 1 cycle.
REQ-017 Command FSM SHALL have states IDLE (cmd_ready=1) and APPLY (cmd_ready=0); accept = cmd_valid & cmd_ready; IDLE->APPLY on accept of non-NOP; APPLY->IDLE unconditionally after 1 cycle.
REQ-018 NOP accept SHALL change nothing and remain IDLE.
REQ-019 FORCE SHALL, on the accept edge, set forced |= cmd_mask and fval[b] = cmd_value[b] for masked bits; unmasked bits untouched.
REQ-020 FORCE with cmd_hold > 0 SHALL set timed |= cmd_mask and (re)load the shared timer with cmd_hold; cmd_hold = 0 SHALL clear timed for masked bits (indefinite force).
REQ-021 RELEASE SHALL clear forced and timed for cmd_mask bits; RELEASE_ALL SHALL clear forced, timed and timer.
REQ-022 Timer SHALL decrement once per cycle while nonzero; on transition 1->0 it SHALL clear forced & timed bits, clear timed, and assert rel_pulse for exactly that next cycle.
REQ-023 If timed becomes zero by release, timer SHALL clear to 0 with no rel_pulse.
REQ-024 Simultaneous expiry and command accept: expiry applied first, then command; a FORCE on the same edge wins for its masked bits.
REQ-025 cmd_hold > HOLD_MAX SHALL saturate to HOLD_MAX.
REQ-026 Forced bits SHALL ignore in_bus toggles completely; released bits SHALL follow raw from the next registered update.

Reset
REQ-027 Asserting rst_n low SHALL immediately clear out_q, forced, fval, timed, timer, rel_pulse to 0, and set FSM to IDLE (cmd_ready=1 after release).
REQ-028 Reset mid-APPLY or mid-hold SHALL abandon the command/hold with no rel_pulse.

Structure
REQ-029 Command opcode enum and FSM state enum SHALL live in shared package or_force_pkg.
REQ-030 Per-bit OR reduction SHALL be sub-module or_reduce_n (params W, N), combinational.
REQ-031 Implementation SHALL fit 120-400 lines RTL, no latches.

Verification
REQ-032 Reset: rst_n=0 with in_bus=4'b1111 -> out_q=0, forced=0, cmd_ready=1.
REQ-033 Pass-through: W=2,N=2, ch0=01, ch1=10, toggle ch1 every 3 cycles -> out_q tracks 11/01 with 1-cycle lag.
REQ-034 Indefinite force: FORCE mask=01 value=00 hold=0 -> out_q[0]=0 for 50 cycles regardless of inputs; RELEASE mask=01 -> out_q[0] follows raw next cycle.
REQ-035 Timed force: FORCE mask=11 value=10 hold=5 -> out_q=10 for 5 cycles, rel_pulse high once, forced=00, out_q=raw after.
REQ-036 Collision: FORCE mask=10 value=10 hold=3 on exact expiry cycle of prior hold -> bit1 stays forced, rel_pulse asserted, timer reloaded to 3.
REQ-037 Reset mid-hold: assert rst_n low at hold cycle 2 -> all outputs 0, no rel_pulse after reset release.

Source files
------------

// File: rtl/or_force_pkg.sv
// Shared types for the OR/force unit: the command opcodes and the command FSM states.
package or_force_pkg;

  typedef enum logic [1:0] {
    OP_NOP         = 2'b00,
    OP_FORCE       = 2'b01,
    OP_RELEASE     = 2'b10,
    OP_RELEASE_ALL = 2'b11
  } cmd_op_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_APPLY = 1'b1
  } state_e;

endpackage

// File: rtl/or_reduce_n.sv
// Combinational per-bit OR across N packed W-bit channels; channel k sits in in_bus[k*W +: W].
module or_reduce_n #(
  parameter int W = 2,
  parameter int N = 2
) (
  input  logic [N*W-1:0] in_bus,
  output logic [W-1:0]   raw
);

  always_comb begin
    raw = '0;
    for (int k = 0; k < N; k++) begin
      raw = raw | in_bus[k*W +: W];
    end
  end

endmodule

// File: rtl/or_force_unit.sv
// Registered OR of N input channels with per-bit overrides: indefinite or timed forces
// sharing one down-counting hold timer, plus a one-cycle command FSM.
//   state    | meaning
//   ST_IDLE  | cmd_ready=1, a non-NOP accept applies its effect on this edge
//   ST_APPLY | cmd_ready=0 for one cycle after a non-NOP accept
module or_force_unit
  import or_force_pkg::*;
#(
  parameter  int W        = 2,
  parameter  int N        = 2,
  parameter  int HOLD_MAX = 15,
  localparam int HW       = $clog2(HOLD_MAX + 1)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N*W-1:0] in_bus,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic [1:0]     cmd_op,
  input  logic [W-1:0]   cmd_mask,
  input  logic [W-1:0]   cmd_value,
  input  logic [HW-1:0]  cmd_hold,
  output logic [W-1:0]   out_q,
  output logic [W-1:0]   forced,
  output logic           rel_pulse
);

  state_e        state_q;
  cmd_op_e       op;
  logic          accept;
  logic [W-1:0]  raw;
  logic [W-1:0]  out_d;
  logic [W-1:0]  forced_q, forced_d;
  logic [W-1:0]  fval_q, fval_d;
  logic [W-1:0]  timed_q, timed_d;
  logic [HW-1:0] timer_q, timer_d;
  logic [HW-1:0] hold_sat;
  logic          rel_q, rel_d;

  or_reduce_n #(.W(W), .N(N)) u_or_reduce (
    .in_bus (in_bus),
    .raw    (raw)
  );

  assign op        = cmd_op_e'(cmd_op);
  assign cmd_ready = (state_q == ST_IDLE);
  assign accept    = cmd_valid & cmd_ready;
  assign hold_sat  = (32'(cmd_hold) > HOLD_MAX) ? HW'(HOLD_MAX) : cmd_hold;
  assign out_d     = (forced_q & fval_q) | (~forced_q & raw);
  assign forced    = forced_q;
  assign rel_pulse = rel_q;

  // Expiry is resolved first so that a FORCE accepted on the expiry edge overrides it.
  always_comb begin
    forced_d = forced_q;
    fval_d   = fval_q;
    timed_d  = timed_q;
    timer_d  = timer_q;
    rel_d    = 1'b0;
    if (timer_q != '0) begin
      timer_d = timer_q - HW'(1);
      if (timer_q == HW'(1)) begin
        forced_d = forced_q & ~timed_q;
        timed_d  = '0;
        rel_d    = 1'b1;
      end
    end
    if (accept) begin
      case (op)
        OP_NOP: ;
        OP_FORCE: begin
          forced_d = forced_d | cmd_mask;
          fval_d   = (fval_d & ~cmd_mask) | (cmd_value & cmd_mask);
          if (cmd_hold != '0) begin
            timed_d = timed_d | cmd_mask;
            timer_d = hold_sat;
          end else begin
            timed_d = timed_d & ~cmd_mask;
          end
        end
        OP_RELEASE: begin
          forced_d = forced_d & ~cmd_mask;
          timed_d  = timed_d & ~cmd_mask;
        end
        OP_RELEASE_ALL: begin
          forced_d = '0;
          timed_d  = '0;
          timer_d  = '0;
        end
      endcase
    end
    // With nothing left on a timed hold the timer is dropped silently.
    if (timed_d == '0) timer_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q    <= '0;
      forced_q <= '0;
      fval_q   <= '0;
      timed_q  <= '0;
      timer_q  <= '0;
      rel_q    <= 1'b0;
    end else begin
      out_q    <= out_d;
      forced_q <= forced_d;
      fval_q   <= fval_d;
      timed_q  <= timed_d;
      timer_q  <= timer_d;
      rel_q    <= rel_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (accept && op != OP_NOP) state_q <= ST_APPLY;
        ST_APPLY: state_q <= ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
